// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//   Shared types and helpers for the game timer.
//   - timer_state_t : top-level timer FSM states
//   - calc_div      : clock cycles per count tick (CLK_HZ / TICK_HZ)
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    // DIV must come out >= 2 and integral; the caller picks CLK_HZ/TICK_HZ.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/game_timer_if.sv
// -----------------------------------------------------------------------------
// game_timer_if
//   Control and status bundle of the game timer.
//   Controls (master -> slave): clear, start, pause, mode_down, load_val
//   Status   (slave -> master): count_out, tick, expired, running
//   master : game logic / testbench driving the timer
//   slave  : the game_timer itself
// -----------------------------------------------------------------------------
interface game_timer_if #(
    parameter int CNT_W = 10
);
    logic             clear;
    logic             start;
    logic             pause;
    logic             mode_down;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] count_out;
    logic             tick;
    logic             expired;
    logic             running;

    modport master (
        output clear, start, pause, mode_down, load_val,
        input  count_out, tick, expired, running
    );

    modport slave (
        input  clear, start, pause, mode_down, load_val,
        output count_out, tick, expired, running
    );
endinterface

// File: rtl/game_timer_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Divides the clock by DIV while enabled. presc runs 0..DIV-1; wrap is high
//   in the cycle presc sits at DIV-1 with en set, and presc returns to 0 on
//   that edge. With en low presc holds, so pausing loses no time.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     en         : advance presc this cycle
//     clr        : force presc to 0 (wins over en)
//     wrap       : combinational wrap strobe, registered by the parent
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic wrap
);
    localparam int             W    = $clog2(DIV);
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] presc_q, presc_d;

    assign wrap = en && !clr && (presc_q == LAST);

    always_comb begin
        presc_d = presc_q;
        if (clr)       presc_d = '0;
        else if (wrap) presc_d = '0;
        else if (en)   presc_d = presc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc_q <= '0;
        else        presc_q <= presc_d;
    end
endmodule

// File: rtl/game_timer.sv
// -----------------------------------------------------------------------------
// game_timer
//   Up/down game timer counting at TICK_HZ from a CLK_HZ clock, with
//   start / pause / clear control, preset load, terminal-count detection and
//   a one-cycle expiry strobe. All status outputs are registered.
//   Ports:
//     CLOCK10M : sole clock (posedge)
//     KEY0     : async active-low reset
//     bus      : game_timer_if slave (controls in, count/tick/expired/running out)
// -----------------------------------------------------------------------------
module game_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ  = 10_000_000,
    parameter int TICK_HZ = 10,
    parameter int CNT_W   = 10
) (
    input logic        CLOCK10M,
    input logic        KEY0,
    game_timer_if.slave bus
);
    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             dir_q, dir_d;
    logic             tick_q, tick_d;
    logic             expired_q, expired_d;
    logic             running_q, running_d;

    logic             active;
    logic             presc_en, presc_clr, wrap;
    logic [CNT_W-1:0] cnt_inc, cnt_dec;

    // RUN and PAUSE share one path: the pause level alone decides whether
    // time advances, so resuming counts in the very cycle pause drops.
    assign active    = (state_q == RUN) || (state_q == PAUSE);
    assign presc_en  = active && !bus.clear && !bus.pause;
    assign presc_clr = bus.clear || (bus.start && !active);

    tick_prescaler #(.DIV(DIV)) u_presc (
        .clk   (CLOCK10M),
        .rst_n (KEY0),
        .en    (presc_en),
        .clr   (presc_clr),
        .wrap  (wrap)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        dir_d     = dir_q;
        tick_d    = 1'b0;
        expired_d = 1'b0;
        cnt_inc   = count_q + 1'b1;
        cnt_dec   = count_q - 1'b1;

        if (bus.clear) begin
            state_d = IDLE;
            count_d = '0;
        end else if (bus.start && !active) begin
            dir_d   = bus.mode_down;
            limit_d = bus.load_val;
            count_d = bus.mode_down ? bus.load_val : '0;
            // A zero preset in down mode has nothing to count: expire now.
            if (bus.mode_down && (bus.load_val == '0)) begin
                state_d   = DONE;
                expired_d = 1'b1;
            end else begin
                state_d   = RUN;
            end
        end else if (active) begin
            if (bus.pause) begin
                state_d = PAUSE;
            end else begin
                state_d = RUN;
                if (wrap) begin
                    tick_d = 1'b1;
                    if (dir_q) begin
                        // Down count is >= 1 in RUN, so this cannot underflow.
                        count_d = cnt_dec;
                        if (cnt_dec == '0) begin
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end
                    end else begin
                        // limit 0 means free-run with natural wrap.
                        count_d = cnt_inc;
                        if ((limit_q != '0) && (cnt_inc == limit_q)) begin
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end
                    end
                end
            end
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge CLOCK10M or negedge KEY0) begin
        if (!KEY0) begin
            state_q   <= IDLE;
            count_q   <= '0;
            limit_q   <= '0;
            dir_q     <= 1'b0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            dir_q     <= dir_d;
            tick_q    <= tick_d;
            expired_q <= expired_d;
            running_q <= running_d;
        end
    end

    assign bus.count_out = count_q;
    assign bus.tick      = tick_q;
    assign bus.expired   = expired_q;
    assign bus.running   = running_q;
endmodule

// File: tb/tb_game_timer.sv
// -----------------------------------------------------------------------------
// tb_game_timer
//   Scoreboard bench for game_timer (CLK_HZ=20, TICK_HZ=2 -> DIV=10, CNT_W=4).
//   Stimulus tasks drive one clock of inputs, step a behavioural model and push
//   the expected outputs; a monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_game_timer;
    localparam int CLK_HZ  = 20;
    localparam int TICK_HZ = 2;
    localparam int CNT_W   = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int MODN    = 1 << CNT_W;

    typedef struct {
        logic [CNT_W-1:0] count;
        logic             tick;
        logic             expired;
        logic             running;
        int               cyc;
        string            tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    game_timer_if #(.CNT_W(CNT_W)) bus ();

    game_timer #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .CNT_W   (CNT_W)
    ) dut (
        .CLOCK10M (clk),
        .KEY0     (rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t  q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc_n    = 0;
    string tag      = "init";

    // Reference model: time-based view of the timer.
    // m_st: 0 idle, 1 running, 2 paused, 3 done.
    // Count is derived from the number of ticks seen since start.
    int m_st = 0, m_rt = 0, m_ticks = 0, m_load = 0;
    bit m_dir = 1'b0;

    task automatic model_step(input bit r, c, s, p, m, input int l, output exp_t e);
        e.tick    = 1'b0;
        e.expired = 1'b0;
        if (!r) begin
            m_st = 0;
        end else if (c) begin
            m_st = 0;
        end else if (s && (m_st == 0 || m_st == 3)) begin
            m_dir = m; m_load = l; m_rt = 0; m_ticks = 0;
            if (m && l == 0) begin m_st = 3; e.expired = 1'b1; end
            else m_st = 1;
        end else if (m_st == 1 || m_st == 2) begin
            if (p) m_st = 2;
            else begin
                m_st = 1;
                m_rt++;
                if (m_rt % DIV == 0) begin
                    m_ticks++;
                    e.tick = 1'b1;
                    if (m_dir ? (m_load == m_ticks) : (m_load != 0 && m_ticks == m_load)) begin
                        m_st = 3;
                        e.expired = 1'b1;
                    end
                end
            end
        end
        if (m_st == 0)  e.count = '0;
        else if (m_dir) e.count = CNT_W'(m_load - m_ticks);
        else            e.count = CNT_W'(m_ticks % MODN);
        e.running = (m_st == 1);
    endtask

    task automatic report(input string name, input logic [6:0] act, input logic [6:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got cnt=%0d tick=%b exp=%b run=%b, want cnt=%0d tick=%b exp=%b run=%b",
                      name, act[6:3], act[2], act[1], act[0], want[6:3], want[2], want[1], want[0]);
    endtask

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            report($sformatf("cyc%0d %s", e.cyc, e.tag),
                   {bus.count_out, bus.tick, bus.expired, bus.running},
                   {e.count, e.tick, e.expired, e.running});
        end
    end

    // One clock of stimulus. Inputs change 2 time units after the falling
    // edge, so the monitor has already sampled; a low r asserts reset there,
    // mid-cycle, and the outputs are checked before any rising edge.
    task automatic cyc(input bit r, c, s, p, m, input logic [CNT_W-1:0] l);
        exp_t e;
        @(negedge clk);
        #2;
        rst_n         = r;
        bus.clear     = c;
        bus.start     = s;
        bus.pause     = p;
        bus.mode_down = m;
        bus.load_val  = l;
        if (!r) begin
            #1;
            report($sformatf("cyc%0d async_reset %s", cyc_n, tag),
                   {bus.count_out, bus.tick, bus.expired, bus.running}, 7'd0);
        end
        @(posedge clk);
        #1;
        model_step(r, c, s, p, m, int'(l), e);
        e.cyc = cyc_n;
        e.tag = tag;
        q.push_back(e);
        cyc_n++;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1, 0, 0, 0, 0, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        bus.clear = 0; bus.start = 0; bus.pause = 0; bus.mode_down = 0; bus.load_val = '0;

        tag = "reset";
        repeat (3) cyc(0, 0, 0, 0, 0, '0);
        idle(3);

        tag = "up_freerun";
        cyc(1, 0, 1, 0, 0, 4'd0);
        idle(175);
        cyc(1, 1, 0, 0, 0, '0);

        tag = "down_3";
        cyc(1, 0, 1, 0, 1, 4'd3);
        idle(40);
        cyc(1, 1, 0, 0, 0, '0);

        tag = "pause_7";
        cyc(1, 0, 1, 0, 0, 4'd0);
        idle(24);
        repeat (7) cyc(1, 0, 0, 1, 0, '0);
        idle(15);
        cyc(1, 1, 0, 0, 0, '0);

        tag = "down_zero";
        cyc(1, 0, 1, 0, 1, 4'd0);
        idle(3);
        cyc(1, 1, 0, 0, 0, '0);

        tag = "up_limit2";
        cyc(1, 0, 1, 0, 0, 4'd2);
        idle(25);
        tag = "restart_done";
        cyc(1, 0, 1, 0, 1, 4'd1);
        idle(12);
        cyc(1, 1, 0, 0, 0, '0);

        tag = "clear_start";
        cyc(1, 0, 1, 0, 0, 4'd0);
        idle(15);
        cyc(1, 1, 1, 0, 0, 4'd7);
        idle(3);

        tag = "start_ignored";
        cyc(1, 0, 1, 0, 1, 4'd9);
        idle(5);
        cyc(1, 0, 1, 0, 0, 4'd2);
        idle(20);
        cyc(1, 1, 0, 0, 0, '0);

        tag = "pause_on_wrap";
        cyc(1, 0, 1, 0, 0, 4'd0);
        idle(9);
        repeat (4) cyc(1, 0, 0, 1, 0, '0);
        idle(15);
        cyc(1, 1, 0, 0, 0, '0);

        tag = "start_pause";
        cyc(1, 0, 1, 1, 0, 4'd0);
        repeat (3) cyc(1, 0, 0, 1, 0, '0);
        idle(12);
        cyc(1, 1, 0, 0, 0, '0);

        tag = "reset_mid_run";
        cyc(1, 0, 1, 0, 0, 4'd0);
        idle(55);
        repeat (2) cyc(0, 0, 0, 0, 0, '0);
        idle(15);
        cyc(1, 0, 1, 0, 1, 4'd2);
        idle(25);

        tag = "random";
        for (int i = 0; i < 3000; i++) begin
            bit r, c, s, p, m;
            logic [CNT_W-1:0] l;
            r = ($urandom % 400) != 0;
            c = ($urandom % 60) == 0;
            s = ($urandom % 12) == 0;
            p = ($urandom % 100) < 20;
            m = $urandom % 2;
            l = (($urandom % 4) == 0) ? '0 : CNT_W'($urandom % MODN);
            cyc(r, c, s, p, m, l);
        end

        idle(2);
        @(negedge clk);
        #2;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
